// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - one requester's operation request and result response channels
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one fixed-latency ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     port0,
    alu_arbiter_if.slave     port1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             rr_ptr;
    logic             owner;
    logic [3:0]       counter;
    logic             grant;
    logic             ready0, ready1;
    logic             accept;
    logic             capture;
    logic             rsp_take;
    logic             rsp_valid0, rsp_valid1;
    logic [WIDTH-1:0] rsp_result0, rsp_result1;
    logic             rsp_zero0, rsp_zero1;

    // Grant: a lone requester wins outright; on contention rr_ptr picks the port.
    always_comb begin
        grant = 1'b0;
        if (port0.req_valid && port1.req_valid) begin
            grant = rr_ptr;
        end else begin
            grant = port1.req_valid;
        end
    end

    // Next-state and handshake decode; ready is masked by rst_n so nothing
    // looks accepted while reset is held.
    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            IDLE: begin
                ready0 = rst_n && !grant && port0.req_valid;
                ready1 = rst_n && grant && port1.req_valid;
                if (ready0 || ready1) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (counter == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_take = owner ? port1.rsp_ready : port0.rsp_ready;
                if (rsp_take) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, latency counter, result capture and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            counter     <= 4'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_valid0  <= 1'b0;
            rsp_valid1  <= 1'b0;
            rsp_result0 <= '0;
            rsp_result1 <= '0;
            rsp_zero0   <= 1'b0;
            rsp_zero1   <= 1'b0;
        end else begin
            if (accept) begin
                owner   <= grant;
                counter <= 4'(ALU_LAT);
                alu_op  <= grant ? port1.req_op : port0.req_op;
                alu_a   <= grant ? port1.req_a  : port0.req_a;
                alu_b   <= grant ? port1.req_b  : port0.req_b;
            end else if (state == EXEC) begin
                counter <= counter - 4'd1;
            end
            if (capture) begin
                if (owner) begin
                    rsp_valid1  <= 1'b1;
                    rsp_result1 <= alu_result;
                    rsp_zero1   <= alu_zero;
                end else begin
                    rsp_valid0  <= 1'b1;
                    rsp_result0 <= alu_result;
                    rsp_zero0   <= alu_zero;
                end
            end
            if (rsp_take) begin
                rsp_valid0 <= 1'b0;
                rsp_valid1 <= 1'b0;
                rr_ptr     <= ~owner;
            end
        end
    end

    assign busy             = (state != IDLE);
    assign port0.req_ready  = ready0;
    assign port1.req_ready  = ready1;
    assign port0.rsp_valid  = rsp_valid0;
    assign port1.rsp_valid  = rsp_valid1;
    assign port0.rsp_result = rsp_result0;
    assign port1.rsp_result = rsp_result1;
    assign port0.rsp_zero   = rsp_zero0;
    assign port1.rsp_zero   = rsp_zero1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;

    logic        req_valid [2];
    logic [3:0]  req_op    [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_result[2];
    logic        rsp_zero  [2];

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter_if #(.WIDTH(32), .OPW(4)) p0 ();
    alu_arbiter_if #(.WIDTH(32), .OPW(4)) p1 ();

    assign p0.req_valid = req_valid[0];
    assign p0.req_op    = req_op[0];
    assign p0.req_a     = req_a[0];
    assign p0.req_b     = req_b[0];
    assign p0.rsp_ready = rsp_ready[0];
    assign p1.req_valid = req_valid[1];
    assign p1.req_op    = req_op[1];
    assign p1.req_a     = req_a[1];
    assign p1.req_b     = req_b[1];
    assign p1.rsp_ready = rsp_ready[1];
    assign req_ready[0]  = p0.req_ready;
    assign req_ready[1]  = p1.req_ready;
    assign rsp_valid[0]  = p0.rsp_valid;
    assign rsp_valid[1]  = p1.rsp_valid;
    assign rsp_result[0] = p0.rsp_result;
    assign rsp_result[1] = p1.rsp_result;
    assign rsp_zero[0]   = p0.rsp_zero;
    assign rsp_zero[1]   = p1.rsp_zero;

    alu_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port0      (p0),
        .port1      (p1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    // ALU model: one register stage, so the result is stable two edges after operands change.
    always @(posedge clk) begin
        if (alu_op == 4'h2)      alu_result <= alu_a + alu_b;
        else if (alu_op == 4'h6) alu_result <= alu_a - alu_b;
        else                     alu_result <= 32'h0;
    end
    assign alu_zero = (alu_result == 32'h0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b1;
            req_op[p]    = 4'($urandom);
            req_a[p]     = $urandom;
            req_b[p]     = $urandom;
            rsp_ready[p] = 1'b1;
        end
        #1;
        n_cmp++;
        if ({req_ready[0], req_ready[1], rsp_valid[0], rsp_valid[1], rsp_zero[0], rsp_zero[1], busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags got rdy=%b%b vld=%b%b zero=%b%b busy=%b want all 0",
                     req_ready[0], req_ready[1], rsp_valid[0], rsp_valid[1], rsp_zero[0], rsp_zero[1], busy);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op, rsp_result[0], rsp_result[1]} !== '0) begin
            n_err++;
            $display("FAIL reset_data got a=%h b=%h op=%h r0=%h r1=%h want 0", alu_a, alu_b, alu_op, rsp_result[0], rsp_result[1]);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b0) begin
            n_err++;
            $display("FAIL first_grant got rdy0=%b rdy1=%b want rdy0=1 rdy1=0", req_ready[0], req_ready[1]);
        end
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            rsp_ready[p] = 1'b0;
        end
        step();
    endtask

    task automatic test_single_op();
        req_valid[0] = 1'b1; req_op[0] = 4'h2; req_a[0] = 32'h5; req_b[0] = 32'h3;
        #1;
        n_cmp++;
        if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready got rdy0=%b rdy1=%b want 1 0", req_ready[0], req_ready[1]);
        end
        step();
        req_valid[0] = 1'b0;
        n_cmp++;
        if (alu_a !== 32'h5 || alu_b !== 32'h3 || alu_op !== 4'h2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_operands got a=%h b=%h op=%h busy=%b want 5 3 2 1", alu_a, alu_b, alu_op, busy);
        end
        step();
        n_cmp++;
        if (rsp_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_early got rsp0_valid=%b at edge1 want 0", rsp_valid[0]);
        end
        step();
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'h8 || rsp_zero[0] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp got v0=%b r=%h z=%b v1=%b want 1 8 0 0", rsp_valid[0], rsp_result[0], rsp_zero[0], rsp_valid[1]);
        end
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready[0] = 1'b0;
        n_cmp++;
        if (rsp_valid[0] !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done got v0=%b busy=%b want 0 0", rsp_valid[0], busy);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_res [2];
        int lat;
        exp_res[0] = 32'h2;
        exp_res[1] = 32'h4;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            req_valid[0] = 1'b1; req_op[0] = 4'h2; req_a[0] = 32'h1; req_b[0] = 32'h1;
            req_valid[1] = 1'b1; req_op[1] = 4'h2; req_a[1] = 32'h2; req_b[1] = 32'h2;
            for (int k = 0; k < 2; k++) begin
                #1;
                n_cmp++;
                if (req_ready[k] !== 1'b1 || req_ready[1-k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL rr_grant round=%0d slot=%0d got rdy0=%b rdy1=%b want port %0d", r, k, req_ready[0], req_ready[1], k);
                end
                step();
                req_valid[k] = 1'b0;
                lat = 0;
                while (!rsp_valid[k] && lat < 20) begin
                    step();
                    lat++;
                end
                n_cmp++;
                if (lat !== 2 || rsp_result[k] !== exp_res[k]) begin
                    n_err++;
                    $display("FAIL rr_result round=%0d port=%0d got lat=%0d res=%h want lat=2 res=%h", r, k, lat, rsp_result[k], exp_res[k]);
                end
                rsp_ready[k] = 1'b1;
                step();
                rsp_ready[k] = 1'b0;
            end
        end
    endtask

    task automatic test_zero_flag();
        int lat;
        req_valid[1] = 1'b1; req_op[1] = 4'h6; req_a[1] = 32'h7; req_b[1] = 32'h7;
        step();
        req_valid[1] = 1'b0;
        lat = 0;
        while (!rsp_valid[1] && lat < 20) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== 2 || rsp_result[1] !== 32'h0 || rsp_zero[1] !== 1'b1) begin
            n_err++;
            $display("FAIL zero_flag got lat=%0d res=%h zero=%b want 2 0 1", lat, rsp_result[1], rsp_zero[1]);
        end
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        req_valid[0] = 1'b1; req_op[0] = 4'h2; req_a[0] = 32'd10; req_b[0] = 32'd20;
        step();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_op[1] = 4'h2; req_a[1] = 32'h1; req_b[1] = 32'h2;
        lat = 0;
        while (!rsp_valid[0] && lat < 20) begin
            step();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'd30 || req_ready[1] !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold cycle=%0d got v0=%b res=%h rdy1=%b busy=%b want 1 1e 0 1", i, rsp_valid[0], rsp_result[0], req_ready[1], busy);
            end
            step();
        end
        rsp_ready[0] = 1'b1;
        #1;
        n_cmp++;
        if (req_ready[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_same_cycle got rdy1=%b during rsp handshake want 0", req_ready[1]);
        end
        step();
        rsp_ready[0] = 1'b0;
        n_cmp++;
        if (rsp_valid[0] !== 1'b0 || req_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_next got v0=%b rdy1=%b want 0 1", rsp_valid[0], req_ready[1]);
        end
        step();
        req_valid[1] = 1'b0;
        lat = 0;
        while (!rsp_valid[1] && lat < 20) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== 2 || rsp_result[1] !== 32'h3) begin
            n_err++;
            $display("FAIL bp_port1 got lat=%0d res=%h want 2 3", lat, rsp_result[1]);
        end
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        int lat;
        req_valid[0] = 1'b1; req_op[0] = 4'h2; req_a[0] = 32'h1; req_b[0] = 32'h1;
        step();
        req_valid[0] = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid[0], rsp_valid[1], busy} !== 3'b000 || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0 || rsp_result[0] !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_clear got v=%b%b busy=%b a=%h b=%h op=%h r0=%h want all 0",
                     rsp_valid[0], rsp_valid[1], busy, alu_a, alu_b, alu_op, rsp_result[0]);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if ({rsp_valid[0], rsp_valid[1], busy} !== 3'b000) begin
                n_err++;
                $display("FAIL midreset_silent cycle=%0d got v=%b%b busy=%b want 000", i, rsp_valid[0], rsp_valid[1], busy);
            end
        end
        req_valid[0] = 1'b1; req_op[0] = 4'h6; req_a[0] = 32'h9; req_b[0] = 32'h4;
        step();
        req_valid[0] = 1'b0;
        lat = 0;
        while (!rsp_valid[0] && lat < 20) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== 2 || rsp_result[0] !== 32'h5 || rsp_zero[0] !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_recover got lat=%0d res=%h zero=%b want 2 5 0", lat, rsp_result[0], rsp_zero[0]);
        end
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready[0] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            req_op[p]    = 4'h0;
            req_a[p]     = 32'h0;
            req_b[p]     = 32'h0;
            rsp_ready[p] = 1'b0;
        end
        test_reset();
        test_single_op();
        test_round_robin();
        test_zero_flag();
        test_backpressure();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
